// File: rtl/quant_pkg.sv
// Shared types, widths and the clamp helper for the result requantizer.
// Product width covers signed 32-bit accumulators times an unsigned 16-bit scale.
package quant_pkg;

  localparam int LANES   = 4;
  localparam int ACC_W   = 32;
  localparam int Q_W     = 8;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 6;
  localparam int CNT_W   = 16;
  localparam int QMIN    = -128;
  localparam int QMAX    = 127;
  localparam int PROD_W  = ACC_W + SCALE_W + 1;
  localparam int T_W     = PROD_W + 2;

  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(47);

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [Q_W-1:0]    q_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef acc_t acc_vec_t [LANES];
  typedef q_t   q_vec_t   [LANES];

  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic [SHIFT_W-1:0] shift;
    q_t                 zero_point;
  } cfg_t;

  localparam cfg_t CFG_DEF = '{scale: SCALE_W'(1), shift: '0, zero_point: '0};

  typedef struct packed {
    q_t   q;
    logic sat;
  } sat_res_t;

  function automatic sat_res_t sat_q(input logic signed [T_W-1:0] t);
    sat_res_t res;
    if (t > T_W'(QMAX)) begin
      res.q   = Q_W'(QMAX);
      res.sat = 1'b1;
    end else if (t < T_W'(QMIN)) begin
      res.q   = Q_W'(QMIN);
      res.sat = 1'b1;
    end else begin
      res.q   = t[Q_W-1:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/quant_lane.sv
// One lane of requantization: round-half-up shift, zero-point offset, clamp to int8.
// Purely combinational; sits between the product register and the output register.
module quant_lane
  import quant_pkg::*;
(
  input  logic signed [PROD_W-1:0] prod,
  input  logic [SHIFT_W-1:0]       shift,
  input  q_t                       zero_point,
  output q_t                       q,
  output logic                     sat
);

  logic signed [PROD_W:0]  prod_x;
  logic signed [PROD_W:0]  bias;
  logic signed [PROD_W:0]  sum;
  logic signed [PROD_W:0]  r;
  logic signed [T_W-1:0]   t;
  sat_res_t                res;

  always_comb begin
    prod_x = (PROD_W+1)'(prod);
    bias   = '0;
    // One extra bit of headroom keeps the rounding add from overflowing.
    if (shift != '0) bias = (PROD_W+1)'(1) << (shift - SHIFT_W'(1));
    sum = prod_x + bias;
    r   = sum >>> shift;
    t   = T_W'(r) + T_W'(zero_point);
    res = sat_q(t);
    q   = res.q;
    sat = res.sat;
  end

endmodule

// File: rtl/result_quantizer.sv
// Two-stage int8 requantizer: S1 registers acc*scale, S2 registers clamped lanes; in->out 2 edges.
// Per-stage valid/ready with a combinational ready chain; config writes only land while idle.
module result_quantizer
  import quant_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  q_t                 cfg_zero_point,
  input  logic               in_valid,
  output logic               in_ready,
  input  acc_vec_t           in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output q_vec_t             out_data,
  output logic [CNT_W-1:0]   sat_count,
  output logic               busy
);

  logic               v1_q, v1_d, v2_q, v2_d;
  prod_t              prod_q [LANES];
  prod_t              prod_d [LANES];
  q_vec_t             q2_q, q2_d, lane_q;
  logic [LANES-1:0]   sat2_q, sat2_d, lane_sat;
  cfg_t               cfg_q, cfg_d;
  logic [CNT_W-1:0]   sat_count_q, sat_count_d;
  logic [CNT_W:0]     sat_sum;
  logic               s1_rdy, s2_rdy, cfg_wr;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    quant_lane u_lane (
      .prod       (prod_q[i]),
      .shift      (cfg_q.shift),
      .zero_point (cfg_q.zero_point),
      .q          (lane_q[i]),
      .sat        (lane_sat[i])
    );
  end

  always_comb begin
    s2_rdy = !v2_q || out_ready;
    s1_rdy = !v1_q || s2_rdy;
    cfg_wr = cfg_we && !(v1_q || v2_q);

    cfg_d = cfg_q;
    if (cfg_wr) begin
      cfg_d.scale      = cfg_scale;
      cfg_d.shift      = (cfg_shift > MAX_SHIFT) ? MAX_SHIFT : cfg_shift;
      cfg_d.zero_point = cfg_zero_point;
    end

    // S1 multiplies with the config that lands on this same edge.
    v1_d   = v1_q;
    prod_d = prod_q;
    if (s1_rdy) begin
      v1_d = in_valid;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++)
          prod_d[i] = prod_t'(in_data[i]) * prod_t'(signed'({1'b0, cfg_d.scale}));
      end
    end

    v2_d   = v2_q;
    q2_d   = q2_q;
    sat2_d = sat2_q;
    if (s2_rdy) begin
      v2_d = v1_q;
      if (v1_q) begin
        q2_d   = lane_q;
        sat2_d = lane_sat;
      end
    end

    sat_sum = {1'b0, sat_count_q};
    for (int i = 0; i < LANES; i++) sat_sum = sat_sum + (CNT_W+1)'(sat2_q[i]);
    sat_count_d = sat_count_q;
    if (cfg_wr) sat_count_d = '0;
    else if (v2_q && out_ready) sat_count_d = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      sat2_q      <= '0;
      cfg_q       <= CFG_DEF;
      sat_count_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
        q2_q[i]   <= '0;
      end
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      sat2_q      <= sat2_d;
      cfg_q       <= cfg_d;
      sat_count_q <= sat_count_d;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= prod_d[i];
        q2_q[i]   <= q2_d[i];
      end
    end
  end

  assign in_ready  = s1_rdy;
  assign out_valid = v2_q;
  assign out_data  = q2_q;
  assign sat_count = sat_count_q;
  assign busy      = v1_q || v2_q;

endmodule

// File: tb/tb_result_quantizer.sv
// Bench for result_quantizer: directed cases with literal expectations plus a random phase,
// all traffic scored against a beat-queue model that tracks age, config and saturation totals.
module tb_result_quantizer;
  import quant_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_we;
  logic [15:0]  cfg_scale;
  logic [5:0]   cfg_shift;
  q_t           cfg_zero_point;
  logic         in_valid, in_ready;
  acc_vec_t     in_data;
  logic         out_valid, out_ready;
  q_vec_t       out_data;
  logic [15:0]  sat_count;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  result_quantizer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_scale      (cfg_scale),
    .cfg_shift      (cfg_shift),
    .cfg_zero_point (cfg_zero_point),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .sat_count      (sat_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exact quotient of acc*scale / 2^shift rounded half up, then zero point; unclamped.
  function automatic longint model_t(input longint acc, input longint scale, input int shift, input int zp);
    longint p, fl, rem;
    p  = acc * scale;
    fl = p;
    if (shift > 0) begin
      fl  = p >>> shift;
      rem = p - (fl <<< shift);
      if (2 * rem >= (longint'(1) <<< shift)) fl = fl + 1;
    end
    return fl + zp;
  endfunction

  function automatic int clamp8(input longint t);
    if (t > 127) return 127;
    if (t < -128) return -128;
    return int'(t);
  endfunction

  typedef struct {
    int q [LANES];
    int nsat;
    int age;
  } exp_t;

  exp_t   exp_q [$];
  exp_t   e;
  longint m_scale = 1;
  int     m_shift = 0;
  int     m_zp = 0;
  longint m_sat = 0;
  int     n;
  bit     exp_ov;
  longint tv;

  // Model state at each falling edge mirrors DUT state; then apply what the next rising edge does.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_scale = 1; m_shift = 0; m_zp = 0; m_sat = 0;
    end else begin
      n = exp_q.size();
      exp_ov = (n > 0) && (exp_q[0].age >= 2);
      check("busy", busy, n != 0);
      check("in_ready", in_ready, (n < 2) || out_ready);
      check("out_valid", out_valid, exp_ov);
      check("sat_count", sat_count, m_sat);
      if (exp_ov)
        for (int i = 0; i < LANES; i++) check("out_data", out_data[i], exp_q[0].q[i]);

      if (cfg_we && n == 0) begin
        m_scale = cfg_scale;
        m_shift = (cfg_shift > 47) ? 47 : int'(cfg_shift);
        m_zp    = int'(cfg_zero_point);
        m_sat   = 0;
      end
      if (exp_ov && out_ready) begin
        m_sat = m_sat + exp_q[0].nsat;
        if (m_sat > 65535) m_sat = 65535;
        void'(exp_q.pop_front());
      end
      for (int i = 0; i < exp_q.size(); i++) exp_q[i].age = exp_q[i].age + 1;
      if (in_valid && ((n < 2) || out_ready)) begin
        e.nsat = 0;
        e.age  = 1;
        for (int i = 0; i < LANES; i++) begin
          tv = model_t(longint'(in_data[i]), m_scale, m_shift, m_zp);
          e.q[i] = clamp8(tv);
          if (tv != longint'(e.q[i])) e.nsat++;
        end
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int scale, input int shift, input int zp);
    cfg_we = 1'b1;
    cfg_scale = 16'(scale);
    cfg_shift = 6'(shift);
    cfg_zero_point = 8'(zp);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_beat(input string tag, input int a0, input int a1, input int a2, input int a3,
                          input int e0, input int e1, input int e2, input int e3);
    in_data[0] = a0; in_data[1] = a1; in_data[2] = a2; in_data[3] = a3;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_s1_only"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_lane0"}, out_data[0], e0);
    check({tag, "_lane1"}, out_data[1], e1);
    check({tag, "_lane2"}, out_data[2], e2);
    check({tag, "_lane3"}, out_data[3], e3);
    tick();
    check({tag, "_drained"}, out_valid, 0);
  endtask

  function automatic acc_t rand_acc();
    case ($urandom_range(0, 3))
      0: return acc_t'(int'($urandom_range(0, 600)) - 300);
      1: return acc_t'($urandom);
      2: return ($urandom_range(0, 1) != 0) ? 32'sh7fffffff : 32'sh80000000;
      default: return acc_t'(int'($urandom_range(0, 200000)) - 100000);
    endcase
  endfunction

  int  k;
  int  outs [$];
  bit  saw_low, acc_now, held;
  int  hold;

  initial begin
    reset = 1'b1;
    cfg_we = 1'b0; cfg_scale = '0; cfg_shift = '0; cfg_zero_point = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) in_data[i] = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sat_count", sat_count, 0);
    for (int i = 0; i < LANES; i++) check("rst_out_data", out_data[i], 0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    run_beat("passthru", 5, -3, 127, -128, 5, -3, 127, -128);
    check("passthru_sat", sat_count, 0);
    run_beat("clamp", 1000, -1000, 128, -129, 127, -128, 127, -128);
    check("clamp_sat", sat_count, 4);

    set_cfg(3, 2, 0);
    check("cfg_clears_sat", sat_count, 0);
    run_beat("round", 5, -5, 2, 0, 4, -4, 2, 0);
    run_beat("round_tie_neg", -10, 0, 0, 0, -7, 0, 0, 0);

    set_cfg(1, 0, -10);
    run_beat("zp", 0, 100, -120, 127, -10, 90, -128, 117);
    check("zp_sat", sat_count, 1);

    // Six back-to-back beats with a consumer stall and a config write that must be ignored.
    k = 0; saw_low = 1'b0; held = 1'b0; hold = 0;
    for (int c = 0; c < 40 && (k < 6 || outs.size() < 6); c++) begin
      in_valid = (k < 6);
      in_data[0] = 10 * k; in_data[1] = 0; in_data[2] = 0; in_data[3] = 0;
      out_ready = !(c >= 3 && c <= 7);
      cfg_we = (c == 5);
      cfg_scale = 16'd2; cfg_shift = 6'd0; cfg_zero_point = 8'sd0;
      #1;
      if (held) check("stall_hold", out_data[0], hold);
      held = out_valid && !out_ready;
      hold = out_data[0];
      acc_now = in_valid && in_ready;
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) outs.push_back(int'(out_data[0]));
      @(posedge clk);
      #1;
      if (acc_now) k++;
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("stream_in_ready_fell", saw_low, 1);
    check("stream_count", outs.size(), 6);
    for (int i = 0; i < outs.size() && i < 6; i++) check("stream_order", outs[i], 10 * i - 10);
    run_beat("cfg_ignored", 1, 1, 1, 1, -9, -9, -9, -9);

    // Reset with two beats held in the pipeline.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data[0] = 50; in_data[1] = 60; in_data[2] = 70; in_data[3] = 80;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_in_ready", in_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    check("rel_sat_count", sat_count, 0);
    check("rel_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_beat", out_valid, 0);
    end
    run_beat("default_cfg", 5, -3, 127, -128, 5, -3, 127, -128);

    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < LANES; i++) in_data[i] = rand_acc();
      cfg_we = ($urandom_range(0, 11) == 0);
      cfg_scale = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 8)) : 16'($urandom);
      cfg_shift = 6'($urandom_range(0, 63));
      cfg_zero_point = 8'($urandom);
      tick();
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/result_quantizer.md
Name: result_quantizer

Overview:
- Output stage directly downstream of the systolic core: consumes one 4-lane vector of 32-bit signed accumulated column results per beat.
- Requantizes each lane to signed 8-bit as `q = sat8(round(acc * scale >> shift) + zero_point)`.
- Presents quantized vectors to the router/NoC side over a valid/ready handshake.
- Two-stage pipeline with per-stage backpressure, a programmable config latch and a saturation event counter.

Parameters:
- LANES, 4, number of result lanes per beat (one per array column)
- ACC_W, 32, accumulator input width, signed
- Q_W, 8, quantized output width, signed
- SCALE_W, 16, multiplier width, unsigned
- SHIFT_W, 6, right-shift amount width
- CNT_W, 16, saturation counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- cfg_we  in  1  config write strobe; honoured only when busy=0
- cfg_scale  in  SCALE_W  multiplier, unsigned
- cfg_shift  in  SHIFT_W  right shift; values >47 treated as 47
- cfg_zero_point  in  Q_W  signed offset added after shift
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  LANES x ACC_W  unpacked array of signed accumulated results; lane i = column i
- out_valid  out  1  output vector valid
- out_ready  in  1  consumer accepts output
- out_data  out  LANES x Q_W  unpacked array of quantized results
- sat_count  out  CNT_W  number of lanes saturated in delivered beats
- busy  out  1  either pipeline stage holds valid data

Behaviour:
- Reset (reset=0, async):
  - stage valids=0, out_valid=0, out_data=0, sat_count=0, busy=0.
  - Config returns to scale=1, shift=0, zero_point=0.
  - In-flight data is discarded.
  - in_ready is a function of the stage valids, so it reads 1 while reset is held and after release.
- Config:
  - cfg_we with busy=0 latches all three fields at the clock edge and clears sat_count.
  - cfg_we with busy=1 is ignored entirely; config and sat_count are unchanged.
  - Config is stable for any beat in flight.
- Handshake:
  - A transfer occurs when valid and ready are both high at a clock edge.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - out_valid is never retracted without a transfer.
- Pipeline:
  - S1 registers `prod_i = signed(acc_i) * signed({1'b0,scale})`, 49-bit signed.
  - S2 registers the final q_i together with per-lane saturation flags.
  - out_valid = S2 valid; out_data = S2 data.
  - Latency: input accepted at edge N appears with out_valid=1 after edge N+2.
  - Throughput: 1 beat/cycle when out_ready stays high.
- Ready chain (combinational, no bubbles held):
  - s2_rdy = !v2 | out_ready
  - s1_rdy = !v1 | s2_rdy
  - in_ready = s1_rdy
  - While stalled, the pipeline holds at most 2 beats; order is preserved and no beat is lost or duplicated.
- Arithmetic, per lane:
  - shift=0: r = prod.
  - shift>0: r = (prod + (1 << (shift-1))) >>> shift. This is round-half-up: ties toward +inf, e.g. -2.5 -> -2. The add is done at full width with no overflow.
  - t = r + sign_ext(zero_point).
  - q = clamp(t, -128, 127). A lane saturates when the clamp changes the value.
- sat_count:
  - On each output transfer, adds the number of saturated lanes in that beat (0..LANES).
  - Saturates at all-ones, no wrap.
- busy = v1 | v2.
- Simultaneous events:
  - An output transfer and a new input in the same cycle both occur; the pipeline advances.
  - cfg_we in the same cycle an input is accepted: busy is sampled pre-edge, so the write applies if busy=0. The accepted beat then uses the new config, because S1 computes from the config latched at that same edge.

Decomposition:
- Package quant_pkg holds:
  - LANES, ACC_W, Q_W, QMIN=-128, QMAX=127
  - typedefs acc_t, q_t, acc_vec_t, q_vec_t
  - cfg_t struct {scale, shift, zero_point}
  - function sat_q(t) returning {q, sat_flag}
- Sub-module quant_lane: combinational round/shift/offset/clamp for one lane. Instantiated LANES times between S1 and S2 registers.

Test Plan:
- Default config, one beat with in_data={5,-3,127,-128} -> out_data={5,-3,127,-128} two cycles after acceptance; sat_count=0.
- Default config, in_data={1000,-1000,128,-129} -> out_data={127,-128,127,-128}; sat_count=4 after the output transfer.
- cfg scale=3, shift=2, zp=0; in_data={5,-5,2,0} -> out_data={4,-4,2,0}, checking round-half-up on 1.5 -> 2 and -3.75 -> -4. Then in_data={-10,0,0,0}, where -7.5 -> -7: out_data={-7,0,0,0}.
- cfg scale=1, shift=0, zp=-10; in_data={0,100,-120,127} -> out_data={-10,90,-128,117}; sat_count=1.
- Stream 6 back-to-back beats with out_ready=0 for cycles 3..7:
  - in_ready falls once 2 beats are held.
  - out_data stays stable through the stall.
  - All 6 beats emerge in order with none lost.
  - cfg_we issued during the stall is ignored, verified by the config readback in the next beat.
- Assert reset mid-stream with 2 beats in flight -> out_valid=0 and busy=0 immediately, async. After release: in_ready=1, config is default, sat_count=0, and the old beats never appear.
